// File: rtl/mips_mem_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encoding, data segment base, word-alignment mask.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_mem_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ARB          = 2'd0;  // only state that issues grants
  localparam logic [1:0] CPU_RD_WAIT  = 2'd1;  // CPU load data returning from RAM
  localparam logic [1:0] HOST_RD_WAIT = 2'd2;  // host read data returning from RAM

  // Default base byte address of the CPU data segment
  localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;

  // Low address bits that must be zero for a word access
  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between requesters (CPU, host), the arbiter and the data RAM.
// Latency: n/a (wires only).
// Backpressure: n/a; the slave modport is the arbiter's view, master is the environment's view.
//   cpu_*  : CPU load/store request, grant, stall and load return
//   host_* : host debug/loader request, grant and read return
//   mem_*  : single-port RAM strobes, address, write data and read data
//   addr_err_o : sticky illegal-access flag
interface data_memory_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [31:0]           cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wdata_i;
  logic                  cpu_gnt_o;
  logic                  cpu_rvalid_o;
  logic [DATA_WIDTH-1:0] cpu_rdata_o;
  logic                  cpu_stall_o;

  logic                  host_req_i;
  logic                  host_we_i;
  logic [31:0]           host_addr_i;
  logic [DATA_WIDTH-1:0] host_wdata_i;
  logic                  host_gnt_o;
  logic                  host_rvalid_o;
  logic [DATA_WIDTH-1:0] host_rdata_o;

  logic                  mem_we_o;
  logic                  mem_re_o;
  logic [31:0]           mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  addr_err_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, cpu_stall_o,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
    output mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output addr_err_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, cpu_stall_o,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
    input  mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  addr_err_o
  );

endinterface

// File: rtl/mem_addr_check.sv
// Range and word-alignment check of a RAM byte offset.
// Latency: combinational.
// Backpressure: none.
//   offset_i : RAM byte offset
//   legal_o  : 1 when offset is inside the RAM and word aligned
module mem_addr_check
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 256
) (
  input  logic [31:0] offset_i,
  output logic        legal_o
);

  localparam logic [31:0] BYTE_LIMIT = 32'(MEMORY_DEPTH * 4);

  assign legal_o = (offset_i < BYTE_LIMIT) && ((offset_i & WORD_ALIGN_MASK) == 32'd0);

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data RAM between the CPU load/store path and the host debug/loader port.
// Latency: grant and RAM strobes in the request cycle; read data returns one cycle later with rvalid.
// Backpressure: CPU is stalled while it lacks the RAM or awaits load data; host holds its request until granted.
//   clk, reset : system clock; reset is asynchronous and active-low
//   bus        : cpu_*, host_*, mem_* and addr_err_o (see data_memory_arbiter_if)
module data_memory_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEMORY_DEPTH  = 256,
  parameter logic [31:0] DATA_BASE     = DATA_BASE_DEFAULT,
  parameter int unsigned HOST_WAIT_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_arbiter_if.slave  bus
);

  localparam int unsigned          CNT_W     = $clog2(HOST_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(HOST_WAIT_MAX);
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] host_wait_cnt_q, host_wait_cnt_d;
  logic             addr_err_q, addr_err_d;
  logic             rd_bad_q, rd_bad_d;   // pending read was illegal: return zero

  logic [31:0] cpu_off;
  logic        cpu_legal, host_legal;
  logic        in_arb, host_wins, cpu_gnt, host_gnt;

  // Data segment offset; addresses below the base wrap to huge offsets and fail the range check
  assign cpu_off = bus.cpu_addr_i - DATA_BASE;

  mem_addr_check #(.MEMORY_DEPTH(MEMORY_DEPTH)) u_cpu_chk (
    .offset_i (cpu_off),
    .legal_o  (cpu_legal)
  );

  mem_addr_check #(.MEMORY_DEPTH(MEMORY_DEPTH)) u_host_chk (
    .offset_i (bus.host_addr_i),
    .legal_o  (host_legal)
  );

  // CPU has priority unless the host has already lost HOST_WAIT_MAX contended cycles
  assign in_arb    = (state_q == ARB);
  assign host_wins = bus.host_req_i & (~bus.cpu_req_i | (host_wait_cnt_q == CNT_MAX));
  assign cpu_gnt   = reset & in_arb & bus.cpu_req_i & ~host_wins;
  assign host_gnt  = reset & in_arb & host_wins;

  assign bus.cpu_gnt_o  = cpu_gnt;
  assign bus.host_gnt_o = host_gnt;

  // RAM drive: strobes are suppressed for illegal accesses but the grant still happens
  always_comb begin
    bus.mem_we_o    = 1'b0;
    bus.mem_re_o    = 1'b0;
    bus.mem_addr_o  = 32'd0;
    bus.mem_wdata_o = ZERO_WORD;
    if (cpu_gnt) begin
      bus.mem_we_o    = cpu_legal & bus.cpu_we_i;
      bus.mem_re_o    = cpu_legal & ~bus.cpu_we_i;
      bus.mem_addr_o  = cpu_off;
      bus.mem_wdata_o = bus.cpu_wdata_i;
    end else if (host_gnt) begin
      bus.mem_we_o    = host_legal & bus.host_we_i;
      bus.mem_re_o    = host_legal & ~bus.host_we_i;
      bus.mem_addr_o  = bus.host_addr_i;
      bus.mem_wdata_o = bus.host_wdata_i;
    end
  end

  // Stall holds the PC; in CPU_RD_WAIT the load completes and the PC advances at this edge
  always_comb begin
    bus.cpu_stall_o = 1'b0;
    case (state_q)
      ARB:          bus.cpu_stall_o = (bus.cpu_req_i & ~cpu_gnt) | (cpu_gnt & ~bus.cpu_we_i);
      CPU_RD_WAIT:  bus.cpu_stall_o = 1'b0;
      HOST_RD_WAIT: bus.cpu_stall_o = bus.cpu_req_i;
      default:      bus.cpu_stall_o = 1'b0;
    endcase
    bus.cpu_stall_o = bus.cpu_stall_o & reset;
  end

  // Read return: rvalid follows the state register, so a reset mid-read drops it at once
  assign bus.cpu_rvalid_o  = (state_q == CPU_RD_WAIT);
  assign bus.host_rvalid_o = (state_q == HOST_RD_WAIT);
  assign bus.cpu_rdata_o   = (state_q == CPU_RD_WAIT  && !rd_bad_q) ? bus.mem_rdata_i : ZERO_WORD;
  assign bus.host_rdata_o  = (state_q == HOST_RD_WAIT && !rd_bad_q) ? bus.mem_rdata_i : ZERO_WORD;
  assign bus.addr_err_o    = addr_err_q;

  always_comb begin
    state_d         = ARB;
    rd_bad_d        = 1'b0;
    host_wait_cnt_d = host_wait_cnt_q;
    addr_err_d      = addr_err_q | (cpu_gnt & ~cpu_legal) | (host_gnt & ~host_legal);

    if (cpu_gnt && !bus.cpu_we_i) begin
      state_d  = CPU_RD_WAIT;
      rd_bad_d = ~cpu_legal;
    end else if (host_gnt && !bus.host_we_i) begin
      state_d  = HOST_RD_WAIT;
      rd_bad_d = ~host_legal;
    end

    // Count contended host losses in ARB; hold through wait states
    if (host_gnt || !bus.host_req_i) begin
      host_wait_cnt_d = '0;
    end else if (in_arb) begin
      host_wait_cnt_d = (host_wait_cnt_q == CNT_MAX) ? CNT_MAX : host_wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ARB;
      host_wait_cnt_q <= '0;
      addr_err_q      <= 1'b0;
      rd_bad_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      host_wait_cnt_q <= host_wait_cnt_d;
      addr_err_q      <= addr_err_d;
      rd_bad_q        <= rd_bad_d;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed self-checking bench for data_memory_arbiter with a small RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_memory_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  data_memory_arbiter_if #(.DATA_WIDTH(32)) bus ();

  data_memory_arbiter #(
    .DATA_WIDTH    (32),
    .MEMORY_DEPTH  (256),
    .DATA_BASE     (32'h1001_0000),
    .HOST_WAIT_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: write at the grant edge, read data valid the following cycle
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (bus.mem_we_o) ram[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
    if (bus.mem_re_o) bus.mem_rdata_i <= ram[bus.mem_addr_o[9:2]];
  end

  task automatic idle_inputs();
    bus.cpu_req_i    = 1'b0;
    bus.cpu_we_i     = 1'b0;
    bus.cpu_addr_i   = 32'd0;
    bus.cpu_wdata_i  = 32'd0;
    bus.host_req_i   = 1'b0;
    bus.host_we_i    = 1'b0;
    bus.host_addr_i  = 32'd0;
    bus.host_wdata_i = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.mem_rdata_i = 32'd0;
    reset = 1'b0;
    bus.cpu_req_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    if (bus.cpu_gnt_o !== 1'b0)    begin errors++; $display("FAIL rst_cpu_gnt got=%0h exp=0", bus.cpu_gnt_o); end checks++;
    if (bus.cpu_stall_o !== 1'b0)  begin errors++; $display("FAIL rst_stall got=%0h exp=0", bus.cpu_stall_o); end checks++;
    if (bus.mem_re_o !== 1'b0)     begin errors++; $display("FAIL rst_mem_re got=%0h exp=0", bus.mem_re_o); end checks++;
    if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%0h exp=0", bus.cpu_rvalid_o); end checks++;
    if (bus.addr_err_o !== 1'b0)   begin errors++; $display("FAIL rst_addr_err got=%0h exp=0", bus.addr_err_o); end checks++;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_store_load();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1;
    bus.cpu_addr_i = 32'h1001_0004; bus.cpu_wdata_i = 32'hDEAD_BEEF;
    #1;
    if (bus.cpu_gnt_o !== 1'b1)          begin errors++; $display("FAIL st_gnt got=%0h exp=1", bus.cpu_gnt_o); end checks++;
    if (bus.mem_we_o !== 1'b1)           begin errors++; $display("FAIL st_mem_we got=%0h exp=1", bus.mem_we_o); end checks++;
    if (bus.mem_addr_o !== 32'd4)        begin errors++; $display("FAIL st_addr got=%0h exp=4", bus.mem_addr_o); end checks++;
    if (bus.mem_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_wdata got=%0h exp=deadbeef", bus.mem_wdata_o); end checks++;
    if (bus.cpu_stall_o !== 1'b0)        begin errors++; $display("FAIL st_stall got=%0h exp=0", bus.cpu_stall_o); end checks++;
    @(negedge clk);
    bus.cpu_we_i = 1'b0;
    #1;
    if (bus.cpu_gnt_o !== 1'b1)   begin errors++; $display("FAIL ld_gnt got=%0h exp=1", bus.cpu_gnt_o); end checks++;
    if (bus.mem_re_o !== 1'b1)    begin errors++; $display("FAIL ld_mem_re got=%0h exp=1", bus.mem_re_o); end checks++;
    if (bus.mem_we_o !== 1'b0)    begin errors++; $display("FAIL ld_mem_we got=%0h exp=0", bus.mem_we_o); end checks++;
    if (bus.cpu_stall_o !== 1'b1) begin errors++; $display("FAIL ld_stall got=%0h exp=1", bus.cpu_stall_o); end checks++;
    @(negedge clk);
    #1;
    if (bus.cpu_rvalid_o !== 1'b1)         begin errors++; $display("FAIL ld_rvalid got=%0h exp=1", bus.cpu_rvalid_o); end checks++;
    if (bus.cpu_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata got=%0h exp=deadbeef", bus.cpu_rdata_o); end checks++;
    if (bus.cpu_stall_o !== 1'b0)          begin errors++; $display("FAIL ld_wait_stall got=%0h exp=0", bus.cpu_stall_o); end checks++;
    if (bus.cpu_gnt_o !== 1'b0)            begin errors++; $display("FAIL ld_wait_gnt got=%0h exp=0", bus.cpu_gnt_o); end checks++;
    @(negedge clk);
    idle_inputs();
    #1;
    if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL ld_rvalid_pulse got=%0h exp=0", bus.cpu_rvalid_o); end checks++;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    bit exp_h;
    bus.cpu_req_i  = 1'b1; bus.cpu_we_i  = 1'b1; bus.cpu_addr_i  = 32'h1001_0000; bus.cpu_wdata_i  = 32'h1111_0000;
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = 32'h10;         bus.host_wdata_i = 32'h2222_0010;
    for (int i = 0; i < 10; i++) begin
      exp_h = (i == 4) || (i == 9);
      #1;
      if (bus.cpu_gnt_o !== !exp_h)  begin errors++; $display("FAIL fair_cpu_gnt cyc=%0d got=%0h exp=%0h", i, bus.cpu_gnt_o, !exp_h); end checks++;
      if (bus.host_gnt_o !== exp_h)  begin errors++; $display("FAIL fair_host_gnt cyc=%0d got=%0h exp=%0h", i, bus.host_gnt_o, exp_h); end checks++;
      if (bus.cpu_stall_o !== exp_h) begin errors++; $display("FAIL fair_stall cyc=%0d got=%0h exp=%0h", i, bus.cpu_stall_o, exp_h); end checks++;
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_host_read();
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = 32'd8; bus.host_wdata_i = 32'hA5A5_0008;
    #1;
    if (bus.host_gnt_o !== 1'b1) begin errors++; $display("FAIL hw_gnt got=%0h exp=1", bus.host_gnt_o); end checks++;
    if (bus.mem_we_o !== 1'b1)   begin errors++; $display("FAIL hw_mem_we got=%0h exp=1", bus.mem_we_o); end checks++;
    @(negedge clk);
    bus.host_we_i = 1'b0;
    #1;
    if (bus.host_gnt_o !== 1'b1)  begin errors++; $display("FAIL hr_gnt got=%0h exp=1", bus.host_gnt_o); end checks++;
    if (bus.mem_re_o !== 1'b1)    begin errors++; $display("FAIL hr_mem_re got=%0h exp=1", bus.mem_re_o); end checks++;
    if (bus.mem_addr_o !== 32'd8) begin errors++; $display("FAIL hr_addr got=%0h exp=8", bus.mem_addr_o); end checks++;
    @(negedge clk);
    bus.host_req_i = 1'b0;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h1001_0004;
    #1;
    if (bus.host_rvalid_o !== 1'b1)         begin errors++; $display("FAIL hr_rvalid got=%0h exp=1", bus.host_rvalid_o); end checks++;
    if (bus.host_rdata_o !== 32'hA5A5_0008) begin errors++; $display("FAIL hr_rdata got=%0h exp=a5a50008", bus.host_rdata_o); end checks++;
    if (bus.cpu_gnt_o !== 1'b0)             begin errors++; $display("FAIL hr_wait_cpu_gnt got=%0h exp=0", bus.cpu_gnt_o); end checks++;
    if (bus.cpu_stall_o !== 1'b1)           begin errors++; $display("FAIL hr_wait_stall got=%0h exp=1", bus.cpu_stall_o); end checks++;
    @(negedge clk);
    #1;
    if (bus.cpu_gnt_o !== 1'b1) begin errors++; $display("FAIL hr_after_cpu_gnt got=%0h exp=1", bus.cpu_gnt_o); end checks++;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_illegal();
    #1;
    if (bus.addr_err_o !== 1'b0) begin errors++; $display("FAIL ill_err_before got=%0h exp=0", bus.addr_err_o); end checks++;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h1001_0400;
    #1;
    if (bus.cpu_gnt_o !== 1'b1)   begin errors++; $display("FAIL ill_ld_gnt got=%0h exp=1", bus.cpu_gnt_o); end checks++;
    if (bus.mem_re_o !== 1'b0)    begin errors++; $display("FAIL ill_ld_mem_re got=%0h exp=0", bus.mem_re_o); end checks++;
    if (bus.cpu_stall_o !== 1'b1) begin errors++; $display("FAIL ill_ld_stall got=%0h exp=1", bus.cpu_stall_o); end checks++;
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    #1;
    if (bus.cpu_rvalid_o !== 1'b1)  begin errors++; $display("FAIL ill_ld_rvalid got=%0h exp=1", bus.cpu_rvalid_o); end checks++;
    if (bus.cpu_rdata_o !== 32'd0)  begin errors++; $display("FAIL ill_ld_rdata got=%0h exp=0", bus.cpu_rdata_o); end checks++;
    if (bus.addr_err_o !== 1'b1)    begin errors++; $display("FAIL ill_ld_err got=%0h exp=1", bus.addr_err_o); end checks++;
    @(negedge clk);
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = 32'd6; bus.host_wdata_i = 32'h0BAD_0006;
    #1;
    if (bus.host_gnt_o !== 1'b1) begin errors++; $display("FAIL ill_hw_gnt got=%0h exp=1", bus.host_gnt_o); end checks++;
    if (bus.mem_we_o !== 1'b0)   begin errors++; $display("FAIL ill_hw_mem_we got=%0h exp=0", bus.mem_we_o); end checks++;
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    if (bus.addr_err_o !== 1'b1) begin errors++; $display("FAIL ill_err_sticky got=%0h exp=1", bus.addr_err_o); end checks++;
    @(negedge clk);
  endtask

  task automatic test_below_base();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    if (bus.addr_err_o !== 1'b0) begin errors++; $display("FAIL bb_err_cleared got=%0h exp=0", bus.addr_err_o); end checks++;
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h1000_FFFC; bus.cpu_wdata_i = 32'h5555_AAAA;
    #1;
    if (bus.cpu_gnt_o !== 1'b1)           begin errors++; $display("FAIL bb_gnt got=%0h exp=1", bus.cpu_gnt_o); end checks++;
    if (bus.mem_we_o !== 1'b0)            begin errors++; $display("FAIL bb_mem_we got=%0h exp=0", bus.mem_we_o); end checks++;
    if (bus.mem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL bb_offset got=%0h exp=fffffffc", bus.mem_addr_o); end checks++;
    @(negedge clk);
    idle_inputs();
    #1;
    if (bus.addr_err_o !== 1'b1) begin errors++; $display("FAIL bb_err got=%0h exp=1", bus.addr_err_o); end checks++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h1001_0004;
    #1;
    if (bus.cpu_gnt_o !== 1'b1) begin errors++; $display("FAIL rmr_gnt got=%0h exp=1", bus.cpu_gnt_o); end checks++;
    @(negedge clk);
    #1;
    if (bus.cpu_rvalid_o !== 1'b1) begin errors++; $display("FAIL rmr_rvalid_pre got=%0h exp=1", bus.cpu_rvalid_o); end checks++;
    reset = 1'b0;
    #1;
    if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rmr_rvalid got=%0h exp=0", bus.cpu_rvalid_o); end checks++;
    if (bus.cpu_rdata_o !== 32'd0) begin errors++; $display("FAIL rmr_rdata got=%0h exp=0", bus.cpu_rdata_o); end checks++;
    if (bus.cpu_gnt_o !== 1'b0)    begin errors++; $display("FAIL rmr_gnt_rst got=%0h exp=0", bus.cpu_gnt_o); end checks++;
    if (bus.cpu_stall_o !== 1'b0)  begin errors++; $display("FAIL rmr_stall got=%0h exp=0", bus.cpu_stall_o); end checks++;
    if (bus.mem_re_o !== 1'b0)     begin errors++; $display("FAIL rmr_mem_re got=%0h exp=0", bus.mem_re_o); end checks++;
    if (bus.addr_err_o !== 1'b0)   begin errors++; $display("FAIL rmr_err got=%0h exp=0", bus.addr_err_o); end checks++;
    repeat (2) @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rmr_rvalid_rel got=%0h exp=0", bus.cpu_rvalid_o); end checks++;
    @(negedge clk);
    #1;
    if (bus.cpu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rmr_rvalid_late got=%0h exp=0", bus.cpu_rvalid_o); end checks++;
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h1001_0004;
    #1;
    if (bus.cpu_gnt_o !== 1'b1) begin errors++; $display("FAIL rmr_arb_gnt got=%0h exp=1", bus.cpu_gnt_o); end checks++;
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    #1;
    if (bus.cpu_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmr_reload got=%0h exp=deadbeef", bus.cpu_rdata_o); end checks++;
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    test_reset();
    test_cpu_store_load();
    test_fairness();
    test_host_read();
    test_illegal();
    test_below_base();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
